mux_2x1_for_16bit: RTL and testbench
====================================

Name: mux_2x1_for_16bit

Overview:
- Registered 16-bit 2-to-1 multiplexer for the 32-bit MIPS datapath.
- Selects one of two 16-bit operands (e.g. immediate/offset halfwords) under a 1-bit select.
- The selection is captured in an output register on the rising clock edge.
- Used wherever a halfword-wide source choice must be presented one cycle later to downstream logic.

Parameters:
- WIDTH, 16, data width of both inputs and the output. The block is specified and verified at 16; other values need not be supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in0  input  16  operand selected when sel=0. Narrower sources are zero-extended by the instantiating logic, so a 1-bit source drives in0[0] with in0[15:1]=0.
- in1  input  16  operand selected when sel=1. Same zero-extension rule as in0.
- sel  input  1  select: 0 -> in0, 1 -> in1.
- out  output  16  registered selected operand.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset:
  - On a rising clk edge with reset=1, out <= 16'h0000, regardless of sel, in0 and in1.
  - reset is sampled only at clk edges. Asserting reset between edges has no effect on out until the next edge.
  - Reset has priority over data capture when both occur at the same edge.
- Normal operation, on each rising clk edge with reset=0:
  - out <= sel ? in1 : in0, evaluated bit-wise.
  - For each bit i: out[i] = (in0[i] & ~sel) | (in1[i] & sel).
- Latency:
  - Exactly 1 cycle from sel/in0/in1 sampled at edge N to out valid after edge N.
  - No handshake, no stall, no enable: the register loads every non-reset cycle.
- Datapath construction:
  - Built as WIDTH identical 1-bit select cells, each made of NOT/AND/OR gates, sharing one sel.
  - A single inverted-select net fans out to all cells.
  - Followed by a WIDTH-bit D flip-flop bank with synchronous reset.
- Boundary and edge cases:
  - sel=X/Z is a verification error, not a design state. No X-masking logic.
  - in0 == in1: out equals that value for either sel.
  - All-ones and all-zeros operands pass through unmodified; there is no sign extension or arithmetic.
  - A sel change between edges has no effect on out until the next edge.
  - Reset released mid-stream: the first edge with reset=0 captures the currently selected operand; no extra bubble cycle.
- Output is glitch-free between edges because it is driven solely by flops.

Test Plan:
- Reset: reset=1 for 2 edges with in0=16'hFFFF, in1=16'hAAAA, sel=1 -> out=16'h0000 after each edge. Release reset -> out=16'hAAAA after the next edge.
- Zero-extended 1-bit sources: in0=16'h0000, in1=16'h0001.
  - sel=0 -> out=16'h0000 one edge later.
  - Then sel=1 -> out=16'h0001 one edge later.
- Swapped operands: in0=16'h0001, in1=16'h0000.
  - sel=0 -> out=16'h0001.
  - sel=1 -> out=16'h0000.
- Full-width independence: in0=16'h5A5A, in1=16'hA5A5; toggle sel every cycle -> out alternates 16'h5A5A / 16'hA5A5 with exactly 1-cycle lag. Every bit is checked individually.
- Reset priority: at a single edge drive reset=1, sel=1, in1=16'h1234 -> out=16'h0000. Next edge with reset=0 -> out=16'h1234.
- Mid-cycle stability: change sel and in0 between edges (in0=16'hFFFF then 16'h0000 before the edge) -> out reflects only the values present at the edge. No intermediate change is visible on out.

Source files
------------

// File: rtl/mux_2x1_for_16bit_if.sv
// Operand/select bundle for the registered 16-bit 2:1 multiplexer.
//   in0  - operand presented when sel=0 (narrow sources zero-extended)
//   in1  - operand presented when sel=1 (narrow sources zero-extended)
//   sel  - select: 0 -> in0, 1 -> in1
//   out  - registered selected operand
// master drives operands/select and observes out; slave is the mux itself.
interface mux_2x1_for_16bit_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             sel;
   logic [WIDTH-1:0] out;

   modport master (
      output in0,
      output in1,
      output sel,
      input  out
   );

   modport slave (
      input  in0,
      input  in1,
      input  sel,
      output out
   );
endinterface

// File: rtl/mux_2x1_for_16bit.sv
// Registered 16-bit 2-to-1 multiplexer for the MIPS datapath.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - synchronous, active-high; clears out to zero, wins over capture
//   bus   - slave side of mux_2x1_for_16bit_if (in0, in1, sel in; out out)
// The selected operand appears on out one cycle after it is sampled.
module mux_2x1_for_16bit #(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   mux_2x1_for_16bit_if.slave  bus
);

   logic             sel_n;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   // One inverted select net shared by every bit cell.
   assign sel_n = ~bus.sel;

   // WIDTH identical NOT/AND/OR select cells.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign out_d[i] = (bus.in0[i] & sel_n) | (bus.in1[i] & bus.sel);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_mux_2x1_for_16bit.sv
module tb_mux_2x1_for_16bit;

   logic clk;
   logic reset;
   int   checks;
   int   passes;

   mux_2x1_for_16bit_if #(.WIDTH(16)) bus ();

   mux_2x1_for_16bit #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the output register holds whatever was chosen at the last edge.
   logic [15:0] model_out;
   logic        model_valid;

   initial model_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) model_out <= 16'h0000;
      else       model_out <= bus.sel ? bus.in1 : bus.in0;
      model_valid <= 1'b1;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_bit(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s bit %0d: got %b expected %b at %0t", name, idx, act, exp, $time);
   endtask

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      if (model_valid) chk("model", bus.out, model_out);
   end

   task automatic drive(input logic r, input logic s, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      reset   = r;
      bus.sel = s;
      bus.in0 = a;
      bus.in1 = b;
   endtask

   task automatic edge_then_check(input string name, input logic [15:0] exp);
      @(posedge clk);
      #1;
      chk(name, bus.out, exp);
   endtask

   logic [15:0] held;
   logic [15:0] exp_v;

   initial begin
      checks  = 0;
      passes  = 0;
      reset   = 1'b1;
      bus.sel = 1'b1;
      bus.in0 = 16'hFFFF;
      bus.in1 = 16'hAAAA;

      // Reset held for two edges, then released.
      edge_then_check("reset_edge1", 16'h0000);
      edge_then_check("reset_edge2", 16'h0000);
      drive(1'b0, 1'b1, 16'hFFFF, 16'hAAAA);
      edge_then_check("reset_release", 16'hAAAA);

      // Zero-extended 1-bit sources.
      drive(1'b0, 1'b0, 16'h0000, 16'h0001);
      edge_then_check("zext_sel0", 16'h0000);
      drive(1'b0, 1'b1, 16'h0000, 16'h0001);
      edge_then_check("zext_sel1", 16'h0001);

      // Swapped operands.
      drive(1'b0, 1'b0, 16'h0001, 16'h0000);
      edge_then_check("swap_sel0", 16'h0001);
      drive(1'b0, 1'b1, 16'h0001, 16'h0000);
      edge_then_check("swap_sel1", 16'h0000);

      // Alternating patterns with sel toggling every cycle, every bit checked.
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, k[0], 16'h5A5A, 16'hA5A5);
         exp_v = k[0] ? 16'hA5A5 : 16'h5A5A;
         @(posedge clk);
         #1;
         for (int b = 0; b < 16; b++) chk_bit("toggle", b, bus.out[b], exp_v[b]);
      end

      // Equal operands pass through for both selects.
      drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
      edge_then_check("equal_sel0", 16'hFFFF);
      drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
      edge_then_check("equal_sel1", 16'hFFFF);

      // Reset wins over capture at the same edge.
      drive(1'b1, 1'b1, 16'h0000, 16'h1234);
      edge_then_check("reset_priority", 16'h0000);
      drive(1'b0, 1'b1, 16'h0000, 16'h1234);
      edge_then_check("after_priority", 16'h1234);

      // Mid-cycle changes must not reach out before the edge.
      @(negedge clk);
      held    = bus.out;
      bus.sel = 1'b0;
      bus.in0 = 16'hFFFF;
      #2;
      chk("midcycle_hold1", bus.out, held);
      bus.in0 = 16'h0000;
      #2;
      chk("midcycle_hold2", bus.out, held);
      edge_then_check("midcycle_capture", 16'h0000);

      // Reset asserted between edges acts only at the next edge.
      drive(1'b0, 1'b1, 16'h0000, 16'hBEEF);
      edge_then_check("pre_async", 16'hBEEF);
      #2;
      reset = 1'b1;
      #1;
      chk("reset_between_edges", bus.out, 16'hBEEF);
      edge_then_check("reset_at_edge", 16'h0000);

      // Randomized traffic, checked by the model process.
      for (int k = 0; k < 300; k++) begin
         drive(($urandom_range(15) == 0), $urandom_range(1),
               16'($urandom), 16'($urandom));
      end
      @(negedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
